// File: rtl/regfile_wb_arbiter_if.sv
// rtl/regfile_wb_arbiter_if.sv - write-back, MDU and regfile write-port signal bundle
interface regfile_wb_arbiter_if #(
    parameter int FIFO_DEPTH = 2
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic          pipe_wb_valid;
    logic          pipe_load_regfile;
    logic [4:0]    pipe_rd;
    logic [31:0]   pipe_rd_data;
    logic          mdu_valid;
    logic [4:0]    mdu_rd;
    logic [31:0]   mdu_data;
    logic          mdu_ready;
    logic          pipe_stall;
    logic          load_regfile;
    logic [4:0]    rd;
    logic [31:0]   rd_in;
    logic [CW-1:0] fifo_count;

    modport slave (
        input  pipe_wb_valid, pipe_load_regfile, pipe_rd, pipe_rd_data,
        input  mdu_valid, mdu_rd, mdu_data,
        output mdu_ready, pipe_stall, load_regfile, rd, rd_in, fifo_count
    );

    modport master (
        output pipe_wb_valid, pipe_load_regfile, pipe_rd, pipe_rd_data,
        output mdu_valid, mdu_rd, mdu_data,
        input  mdu_ready, pipe_stall, load_regfile, rd, rd_in, fifo_count
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - shares the regfile write port between WB and a buffered MDU
module regfile_wb_arbiter #(
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    regfile_wb_arbiter_if.slave  bus
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    logic [FIFO_DEPTH-1:0] live_q;
    logic [4:0]            rd_q   [FIFO_DEPTH];
    logic [31:0]           data_q [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         count;
    logic [SW-1:0]         starve;

    logic pipe_req;
    logic fifo_empty;
    logic fifo_full;
    logic head_live;
    logic mdu_win;
    logic pipe_grant;
    logic enq_store;
    logic deq;

    always_comb begin
        pipe_req   = bus.pipe_wb_valid & bus.pipe_load_regfile & (bus.pipe_rd != 5'd0);
        fifo_empty = (count == '0);
        fifo_full  = (count == FULL_COUNT);
        head_live  = !fifo_empty && live_q[rd_ptr];
        mdu_win    = head_live && (!pipe_req || fifo_full || (starve == STARVE_MAX));
        pipe_grant = pipe_req && !mdu_win;
        // x0 results complete the handshake but never occupy a slot
        enq_store  = bus.mdu_valid && !fifo_full && (bus.mdu_rd != 5'd0);
        deq        = !fifo_empty && (!live_q[rd_ptr] || mdu_win);
    end

    assign bus.mdu_ready  = !fifo_full;
    assign bus.pipe_stall = pipe_req & mdu_win;
    assign bus.fifo_count = count;

    always_ff @(posedge clk) begin
        if (enq_store) begin
            rd_q[wr_ptr]   <= bus.mdu_rd;
            data_q[wr_ptr] <= bus.mdu_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            live_q <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            starve <= '0;
        end else begin
            // A granted pipeline write is younger than anything queued for the same rd
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                if (pipe_grant && (rd_q[i] == bus.pipe_rd)) begin
                    live_q[i] <= 1'b0;
                end
            end
            if (enq_store) begin
                live_q[wr_ptr] <= !(pipe_grant && (bus.mdu_rd == bus.pipe_rd));
                wr_ptr         <= wr_ptr + 1'b1;
            end
            if (deq) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({enq_store, deq})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (fifo_empty || deq) begin
                starve <= '0;
            end else if (starve != STARVE_MAX) begin
                starve <= starve + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.load_regfile <= 1'b0;
            bus.rd           <= '0;
            bus.rd_in        <= '0;
        end else if (mdu_win) begin
            bus.load_regfile <= 1'b1;
            bus.rd           <= rd_q[rd_ptr];
            bus.rd_in        <= data_q[rd_ptr];
        end else if (pipe_grant) begin
            bus.load_regfile <= 1'b1;
            bus.rd           <= bus.pipe_rd;
            bus.rd_in        <= bus.pipe_rd_data;
        end else begin
            bus.load_regfile <= 1'b0;
        end
    end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - directed self-checking bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    regfile_wb_arbiter_if #(.FIFO_DEPTH(2)) bus ();

    regfile_wb_arbiter #(.FIFO_DEPTH(2), .STARVE_LIMIT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pipe(input logic v, input logic ld, input logic [4:0] r, input logic [31:0] d);
        bus.pipe_wb_valid     = v;
        bus.pipe_load_regfile = ld;
        bus.pipe_rd           = r;
        bus.pipe_rd_data      = d;
    endtask

    task automatic set_mdu(input logic v, input logic [4:0] r, input logic [31:0] d);
        bus.mdu_valid = v;
        bus.mdu_rd    = r;
        bus.mdu_data  = d;
    endtask

    task automatic set_idle();
        set_pipe(1'b0, 1'b0, 5'd0, 32'd0);
        set_mdu(1'b0, 5'd0, 32'd0);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_pipe(1'($urandom), 1'($urandom), 5'($urandom), $urandom);
            set_mdu(1'($urandom), 5'($urandom), $urandom);
            tick();
        end
        n_cmp++; if (bus.load_regfile !== 1'b0) begin n_bad++; $display("FAIL reset_load: got %0d expected 0", bus.load_regfile); end
        n_cmp++; if (bus.fifo_count !== 2'd0) begin n_bad++; $display("FAIL reset_count: got %0d expected 0", bus.fifo_count); end
        n_cmp++; if (bus.mdu_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %0d expected 1", bus.mdu_ready); end
        n_cmp++; if (bus.rd !== 5'd0 || bus.rd_in !== 32'd0) begin n_bad++; $display("FAIL reset_port: got rd=%0d data=%0h expected 0/0", bus.rd, bus.rd_in); end
        set_idle();
        #2 rst = 1'b1;
        tick();
        n_cmp++; if (bus.load_regfile !== 1'b0) begin n_bad++; $display("FAIL release_load: got %0d expected 0", bus.load_regfile); end
        n_cmp++; if (bus.fifo_count !== 2'd0) begin n_bad++; $display("FAIL release_count: got %0d expected 0", bus.fifo_count); end
    endtask

    task automatic test_pipe_only();
        set_pipe(1'b1, 1'b1, 5'd5, 32'hDEADBEEF);
        #1;
        n_cmp++; if (bus.pipe_stall !== 1'b0) begin n_bad++; $display("FAIL pipe_stall: got %0d expected 0", bus.pipe_stall); end
        tick();
        n_cmp++; if (bus.load_regfile !== 1'b1 || bus.rd !== 5'd5 || bus.rd_in !== 32'hDEADBEEF) begin n_bad++; $display("FAIL pipe_write: got %0d/%0d/%0h expected 1/5/deadbeef", bus.load_regfile, bus.rd, bus.rd_in); end
        set_pipe(1'b1, 1'b1, 5'd0, 32'h1234);
        #1;
        n_cmp++; if (bus.pipe_stall !== 1'b0) begin n_bad++; $display("FAIL pipe_x0_stall: got %0d expected 0", bus.pipe_stall); end
        tick();
        n_cmp++; if (bus.load_regfile !== 1'b0) begin n_bad++; $display("FAIL pipe_x0_write: got %0d expected 0", bus.load_regfile); end
        set_pipe(1'b1, 1'b0, 5'd6, 32'h5678);
        tick();
        n_cmp++; if (bus.load_regfile !== 1'b0) begin n_bad++; $display("FAIL pipe_noload_write: got %0d expected 0", bus.load_regfile); end
        n_cmp++; if (bus.rd !== 5'd5 || bus.rd_in !== 32'hDEADBEEF) begin n_bad++; $display("FAIL pipe_hold: got %0d/%0h expected 5/deadbeef", bus.rd, bus.rd_in); end
        set_idle();
    endtask

    task automatic test_idle_drain();
        set_mdu(1'b1, 5'd7, 32'h12);
        #1;
        n_cmp++; if (bus.mdu_ready !== 1'b1) begin n_bad++; $display("FAIL drain_ready: got %0d expected 1", bus.mdu_ready); end
        tick();
        set_idle();
        n_cmp++; if (bus.fifo_count !== 2'd1) begin n_bad++; $display("FAIL drain_count1: got %0d expected 1", bus.fifo_count); end
        n_cmp++; if (bus.load_regfile !== 1'b0) begin n_bad++; $display("FAIL drain_no_bypass: got %0d expected 0", bus.load_regfile); end
        tick();
        n_cmp++; if (bus.load_regfile !== 1'b1 || bus.rd !== 5'd7 || bus.rd_in !== 32'h12) begin n_bad++; $display("FAIL drain_write: got %0d/%0d/%0h expected 1/7/12", bus.load_regfile, bus.rd, bus.rd_in); end
        n_cmp++; if (bus.fifo_count !== 2'd0) begin n_bad++; $display("FAIL drain_count0: got %0d expected 0", bus.fifo_count); end
        set_mdu(1'b1, 5'd0, 32'h77);
        tick();
        set_idle();
        n_cmp++; if (bus.fifo_count !== 2'd0) begin n_bad++; $display("FAIL x0_drop_count: got %0d expected 0", bus.fifo_count); end
        tick();
        n_cmp++; if (bus.load_regfile !== 1'b0) begin n_bad++; $display("FAIL x0_drop_write: got %0d expected 0", bus.load_regfile); end
    endtask

    task automatic test_starvation();
        set_pipe(1'b1, 1'b1, 5'd1, 32'd100);
        set_mdu(1'b1, 5'd3, 32'h33);
        tick();
        set_mdu(1'b0, 5'd0, 32'd0);
        n_cmp++; if (bus.rd !== 5'd1 || bus.fifo_count !== 2'd1) begin n_bad++; $display("FAIL starve_setup: got rd=%0d cnt=%0d expected 1/1", bus.rd, bus.fifo_count); end
        for (int k = 0; k < 4; k++) begin
            set_pipe(1'b1, 1'b1, 5'(10 + k), 32'(k));
            #1;
            n_cmp++; if (bus.pipe_stall !== 1'b0) begin n_bad++; $display("FAIL starve_grant%0d: got stall=%0d expected 0", k, bus.pipe_stall); end
            tick();
            n_cmp++; if (bus.load_regfile !== 1'b1 || bus.rd !== 5'(10 + k)) begin n_bad++; $display("FAIL starve_write%0d: got %0d/%0d expected 1/%0d", k, bus.load_regfile, bus.rd, 10 + k); end
        end
        set_pipe(1'b1, 1'b1, 5'd20, 32'h99);
        #1;
        n_cmp++; if (bus.pipe_stall !== 1'b1) begin n_bad++; $display("FAIL starve_stall: got %0d expected 1", bus.pipe_stall); end
        tick();
        n_cmp++; if (bus.load_regfile !== 1'b1 || bus.rd !== 5'd3 || bus.rd_in !== 32'h33) begin n_bad++; $display("FAIL starve_mdu_write: got %0d/%0d/%0h expected 1/3/33", bus.load_regfile, bus.rd, bus.rd_in); end
        n_cmp++; if (bus.pipe_stall !== 1'b0 || bus.fifo_count !== 2'd0) begin n_bad++; $display("FAIL starve_release: got stall=%0d cnt=%0d expected 0/0", bus.pipe_stall, bus.fifo_count); end
        tick();
        n_cmp++; if (bus.rd !== 5'd20 || bus.rd_in !== 32'h99) begin n_bad++; $display("FAIL starve_held_write: got %0d/%0h expected 20/99", bus.rd, bus.rd_in); end
        set_idle();
        tick();
    endtask

    task automatic test_full();
        set_pipe(1'b1, 1'b1, 5'd1, 32'hA1);
        set_mdu(1'b1, 5'd10, 32'h100);
        tick();
        set_pipe(1'b1, 1'b1, 5'd2, 32'hA2);
        set_mdu(1'b1, 5'd11, 32'h101);
        #1;
        n_cmp++; if (bus.pipe_stall !== 1'b0) begin n_bad++; $display("FAIL full_b_stall: got %0d expected 0", bus.pipe_stall); end
        tick();
        set_pipe(1'b1, 1'b1, 5'd4, 32'hA4);
        set_mdu(1'b1, 5'd12, 32'h102);
        #1;
        n_cmp++; if (bus.fifo_count !== 2'd2 || bus.mdu_ready !== 1'b0 || bus.pipe_stall !== 1'b1) begin n_bad++; $display("FAIL full_state: got cnt=%0d ready=%0d stall=%0d expected 2/0/1", bus.fifo_count, bus.mdu_ready, bus.pipe_stall); end
        tick();
        n_cmp++; if (bus.rd !== 5'd10 || bus.rd_in !== 32'h100 || bus.fifo_count !== 2'd1) begin n_bad++; $display("FAIL full_drain10: got %0d/%0h cnt=%0d expected 10/100/1", bus.rd, bus.rd_in, bus.fifo_count); end
        n_cmp++; if (bus.mdu_ready !== 1'b1 || bus.pipe_stall !== 1'b0) begin n_bad++; $display("FAIL full_space: got ready=%0d stall=%0d expected 1/0", bus.mdu_ready, bus.pipe_stall); end
        tick();
        set_pipe(1'b1, 1'b1, 5'd6, 32'hA6);
        set_mdu(1'b0, 5'd0, 32'd0);
        n_cmp++; if (bus.rd !== 5'd4 || bus.rd_in !== 32'hA4 || bus.fifo_count !== 2'd2) begin n_bad++; $display("FAIL full_pipe4: got %0d/%0h cnt=%0d expected 4/a4/2", bus.rd, bus.rd_in, bus.fifo_count); end
        #1;
        n_cmp++; if (bus.pipe_stall !== 1'b1) begin n_bad++; $display("FAIL full_refill_stall: got %0d expected 1", bus.pipe_stall); end
        tick();
        n_cmp++; if (bus.rd !== 5'd11 || bus.rd_in !== 32'h101) begin n_bad++; $display("FAIL full_drain11: got %0d/%0h expected 11/101", bus.rd, bus.rd_in); end
        tick();
        set_idle();
        n_cmp++; if (bus.rd !== 5'd6 || bus.fifo_count !== 2'd1) begin n_bad++; $display("FAIL full_pipe6: got %0d cnt=%0d expected 6/1", bus.rd, bus.fifo_count); end
        tick();
        n_cmp++; if (bus.rd !== 5'd12 || bus.rd_in !== 32'h102 || bus.fifo_count !== 2'd0) begin n_bad++; $display("FAIL full_drain12: got %0d/%0h cnt=%0d expected 12/102/0", bus.rd, bus.rd_in, bus.fifo_count); end
        tick();
    endtask

    task automatic test_kill();
        set_mdu(1'b1, 5'd9, 32'hAA);
        tick();
        set_mdu(1'b0, 5'd0, 32'd0);
        set_pipe(1'b1, 1'b1, 5'd9, 32'hBB);
        #1;
        n_cmp++; if (bus.pipe_stall !== 1'b0) begin n_bad++; $display("FAIL kill_stall: got %0d expected 0", bus.pipe_stall); end
        tick();
        set_idle();
        n_cmp++; if (bus.rd !== 5'd9 || bus.rd_in !== 32'hBB || bus.fifo_count !== 2'd1) begin n_bad++; $display("FAIL kill_pipe_write: got %0d/%0h cnt=%0d expected 9/bb/1", bus.rd, bus.rd_in, bus.fifo_count); end
        tick();
        n_cmp++; if (bus.load_regfile !== 1'b0 || bus.fifo_count !== 2'd0) begin n_bad++; $display("FAIL kill_dead_deq: got load=%0d cnt=%0d expected 0/0", bus.load_regfile, bus.fifo_count); end
        set_mdu(1'b1, 5'd8, 32'hCC);
        set_pipe(1'b1, 1'b1, 5'd8, 32'hDD);
        tick();
        set_idle();
        n_cmp++; if (bus.rd_in !== 32'hDD || bus.fifo_count !== 2'd1) begin n_bad++; $display("FAIL kill_same_cycle: got %0h cnt=%0d expected dd/1", bus.rd_in, bus.fifo_count); end
        tick();
        n_cmp++; if (bus.load_regfile !== 1'b0 || bus.rd_in !== 32'hDD) begin n_bad++; $display("FAIL kill_same_deq: got load=%0d data=%0h expected 0/dd", bus.load_regfile, bus.rd_in); end
        set_mdu(1'b1, 5'd12, 32'h1);
        set_pipe(1'b1, 1'b1, 5'd1, 32'h2);
        tick();
        set_mdu(1'b0, 5'd0, 32'd0);
        set_pipe(1'b1, 1'b1, 5'd2, 32'h3);
        #2 rst = 1'b0;
        #1;
        n_cmp++; if (bus.fifo_count !== 2'd0 || bus.load_regfile !== 1'b0) begin n_bad++; $display("FAIL async_reset: got cnt=%0d load=%0d expected 0/0", bus.fifo_count, bus.load_regfile); end
        set_idle();
        tick();
        rst = 1'b1;
        tick();
        n_cmp++; if (bus.load_regfile !== 1'b0 || bus.fifo_count !== 2'd0) begin n_bad++; $display("FAIL async_release: got load=%0d cnt=%0d expected 0/0", bus.load_regfile, bus.fifo_count); end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst   = 1'b0;
        set_idle();
        test_reset();
        test_pipe_only();
        test_idle_drain();
        test_starvation();
        test_full();
        test_kill();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port between the in-order pipeline write-back stage and the out-of-order-completing multiply/divide unit (MDU).
- MDU results are buffered in a small FIFO and drained into idle write-port cycles. The pipeline is stalled only when the FIFO is full or its head has starved.
- Sits between WB and the ID-stage regfile and drives the regfile's load_regfile/rd/rd_in inputs.

Parameters:
- FIFO_DEPTH, 2, MDU result buffer entries (power of 2, >=2).
- STARVE_LIMIT, 4, consecutive lost arbitrations before the FIFO head is forced to win.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- pipe_wb_valid  in  1  WB stage holds a valid instruction.
- pipe_load_regfile  in  1  WB instruction writes rd.
- pipe_rd  in  5  WB destination register.
- pipe_rd_data  in  32  WB write data (regfilemux output).
- mdu_valid  in  1  MDU result offered.
- mdu_rd  in  5  MDU destination register.
- mdu_data  in  32  MDU result.
- mdu_ready  out  1  FIFO accepts a result this cycle.
- pipe_stall  out  1  WB write not granted; pipeline holds all WB inputs.
- load_regfile  out  1  regfile write enable (registered).
- rd  out  5  regfile write address (registered).
- rd_in  out  32  regfile write data (registered).
- fifo_count  out  $clog2(FIFO_DEPTH)+1  occupied entries.

Behaviour:
- Reset (rst=0, async):
  - load_regfile=0, rd=0, rd_in=0.
  - FIFO emptied; fifo_count=0; starve counter=0.
  - mdu_ready=1 after release.
  - Entries in flight at reset are discarded; no partial write.
- pipe_req = pipe_wb_valid & pipe_load_regfile & (pipe_rd!=0). WB instructions without pipe_req never stall and never use the port.
- Enqueue: when mdu_valid & mdu_ready.
  - mdu_ready = (fifo_count < FIFO_DEPTH), combinational from registered count. No same-cycle bypass: an accepted result always spends at least 1 cycle in the FIFO.
  - mdu_rd==0 results are accepted and dropped (not stored).
- Each FIFO entry holds {live, rd, data}.
- Kill rule: in any cycle the pipeline is granted, every stored entry with rd==pipe_rd has live cleared, so an older MDU result never overwrites a younger pipeline write.
  - An entry enqueued in the same cycle with a matching rd is also stored dead.
- Head handling per cycle (FIFO non-empty):
  - Dead head: dequeued silently, no port use, no effect on the pipeline grant.
  - Live head wins (mdu_win) when any of: no pipe_req; fifo_count==FIFO_DEPTH; starve==STARVE_LIMIT.
  - Otherwise the pipeline wins.
- pipe_stall = pipe_req & mdu_win (combinational).
- Write port: the winner's {1, rd, data} is registered and appears at load_regfile/rd/rd_in the next cycle; otherwise load_regfile=0 next cycle (rd/rd_in hold). Fixed latency 1 cycle from grant to regfile inputs.
- Starve counter:
  - +1 (saturating at STARVE_LIMIT) each cycle a live head loses.
  - Cleared when the head dequeues or the FIFO is empty.
- Simultaneous enqueue and dequeue: count unchanged; pointers wrap modulo FIFO_DEPTH.
- Full FIFO with mdu_valid: mdu_ready=0; the MDU must hold its result.

Test Plan:
- Reset: hold rst=0 with random inputs -> load_regfile=0, fifo_count=0, mdu_ready=1; no write for 1 cycle after release.
- Pipe-only: pipe_req rd=5 data=0xDEADBEEF -> next cycle load_regfile=1, rd=5, rd_in=0xDEADBEEF; pipe_stall=0 throughout.
- Idle drain: mdu_valid rd=7 data=0x12 with pipeline idle -> fifo_count=1 next cycle, regfile write rd=7 data=0x12 the cycle after, fifo_count back to 0.
- Starvation: one MDU entry rd=3 queued, pipe_req every cycle (rd!=3) -> pipeline granted 4 cycles, 5th cycle pipe_stall=1 and MDU rd=3 written; starve counter cleared.
- Full: enqueue 2 MDU results under continuous pipe_req -> mdu_ready=0, pipe_stall=1 while fifo_count=2; a third mdu_valid is held until space opens.
- Kill: MDU rd=9 data=0xAA queued, then pipeline granted rd=9 data=0xBB -> only 0xBB reaches x9; the dead entry dequeues with no write; async reset mid-queue -> fifo_count=0 immediately.
